// File: rtl/demux_1_to_2_stream.sv
// Registered 1-to-2 stream demultiplexer with per-packet route locking and valid/ready handshake.
// Optional per-port delivered-packet counters (cnt0/cnt1) when DEMUX_CNT_EN is defined.
module demux_1_to_2_stream #(
  parameter int width = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] y0_data,
  output logic             y0_last,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [width-1:0] y1_data,
  output logic             y1_last,
  output logic             y1_valid,
  input  logic             y1_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       dest;
  logic       accept;
  logic [1:0] out_ready;
  logic [1:0] can_load;
  logic [1:0] load;

  assign out_ready = {y1_ready, y0_ready};

  // The locked selection only applies once the first beat of a packet has been taken.
  assign dest     = (state_q == IDLE) ? in_sel : sel_q;
  assign in_ready = dest ? can_load[1] : can_load[0];
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d = LOCKED;
            sel_d   = in_sel;
          end
        end
        LOCKED: begin
          if (in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_slot
    logic             valid_q;
    logic             last_q;
    logic [width-1:0] data_q;

    assign can_load[n] = !valid_q || out_ready[n];
    assign load[n]     = accept && (dest == 1'(n));

    // NOTE: the data register is reset too, because the outputs must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
      end else if (load[n]) begin
        valid_q <= 1'b1;
        last_q  <= in_last;
        data_q  <= in_data;
      end else if (out_ready[n]) begin
        valid_q <= 1'b0;
      end
    end

`ifdef DEMUX_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (valid_q && out_ready[n] && last_q) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
`endif
  end

  assign y0_valid = g_slot[0].valid_q;
  assign y0_last  = g_slot[0].last_q;
  assign y0_data  = g_slot[0].data_q;
  assign y1_valid = g_slot[1].valid_q;
  assign y1_last  = g_slot[1].last_q;
  assign y1_data  = g_slot[1].data_q;

`ifdef DEMUX_CNT_EN
  assign cnt0 = g_slot[0].cnt_q;
  assign cnt1 = g_slot[1].cnt_q;
`endif

endmodule

// File: tb/tb_demux_1_to_2_stream.sv
// Self-checking bench for demux_1_to_2_stream: directed vector table, reset sequence,
// and randomized traffic against a packet-level reference model.
module tb_demux_1_to_2_stream;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_sel, in_last, in_valid, in_ready;
  logic [W-1:0] y0_data, y1_data;
  logic         y0_last, y0_valid, y0_ready;
  logic         y1_last, y1_valid, y1_ready;
`ifdef DEMUX_CNT_EN
  logic [15:0]  cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1_to_2_stream #(.width(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0_data  (y0_data),
    .y0_last  (y0_last),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y1_data  (y1_data),
    .y1_last  (y1_last),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  typedef struct {
    logic         v, sel, last;
    logic [W-1:0] d;
    logic         r0, r1;
    logic         exp_rdy;
    logic         e0v;
    logic [W-1:0] e0d;
    logic         e0l;
    logic         e1v;
    logic [W-1:0] e1d;
    logic         e1l;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: one-entry slot per output plus packet routing memory.
  logic         m_full [2];
  logic [W-1:0] m_data [2];
  logic         m_last [2];
  logic         m_mid;
  logic         m_dest;
  int           m_cnt  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic last, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    in_valid = v;
    in_sel   = sel;
    in_last  = last;
    in_data  = d;
    y0_ready = r0;
    y1_ready = r1;
  endtask

  function automatic vec_t mk(input logic v, input logic sel, input logic last, input logic [W-1:0] d,
                              input logic r0, input logic r1, input logic rdy,
                              input logic e0v, input logic [W-1:0] e0d, input logic e0l,
                              input logic e1v, input logic [W-1:0] e1d, input logic e1l);
    vec_t t;
    t.v = v; t.sel = sel; t.last = last; t.d = d; t.r0 = r0; t.r1 = r1;
    t.exp_rdy = rdy;
    t.e0v = e0v; t.e0d = e0d; t.e0l = e0l;
    t.e1v = e1v; t.e1d = e1d; t.e1l = e1l;
    return t;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_full[n] = 1'b0;
      m_data[n] = '0;
      m_last[n] = 1'b0;
      m_cnt[n]  = 0;
    end
    m_mid  = 1'b0;
    m_dest = 1'b0;
  endtask

  task automatic check_outputs_vs_model(input string tag);
    check({tag, "_y0_valid"}, 32'(y0_valid), 32'(m_full[0]));
    check({tag, "_y1_valid"}, 32'(y1_valid), 32'(m_full[1]));
    if (m_full[0]) begin
      check({tag, "_y0_data"}, 32'(y0_data), 32'(m_data[0]));
      check({tag, "_y0_last"}, 32'(y0_last), 32'(m_last[0]));
    end
    if (m_full[1]) begin
      check({tag, "_y1_data"}, 32'(y1_data), 32'(m_data[1]));
      check({tag, "_y1_last"}, 32'(y1_last), 32'(m_last[1]));
    end
`ifdef DEMUX_CNT_EN
    check({tag, "_cnt0"}, 32'(cnt0), 32'(m_cnt[0] % 65536));
    check({tag, "_cnt1"}, 32'(cnt1), 32'(m_cnt[1] % 65536));
`endif
  endtask

  initial begin
    logic         exp_rdy, d, acc;
    logic [1:0]   rdy;
    logic [W-1:0] rd;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #3;
    check("reset_y0_valid", 32'(y0_valid), 32'd0);
    check("reset_y1_valid", 32'(y1_valid), 32'd0);
    check("reset_y0_data",  32'(y0_data),  32'd0);
    check("reset_y1_data",  32'(y1_data),  32'd0);
    check("reset_y0_last",  32'(y0_last),  32'd0);
    check("reset_y1_last",  32'(y1_last),  32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table: inputs applied before an edge, outputs expected just after it.
    // single-beat routing to y1, then idle drain
    vecs.push_back(mk(1, 1, 1, 10'h155, 1, 1, 1,  0, 10'h000, 0,  1, 10'h155, 1));
    vecs.push_back(mk(0, 0, 0, 10'h000, 1, 1, 1,  0, 10'h000, 0,  0, 10'h000, 0));
    // 3-beat packet locked to y0 although in_sel flips to 1 on beats 2-3
    vecs.push_back(mk(1, 0, 0, 10'h001, 1, 1, 1,  1, 10'h001, 0,  0, 10'h000, 0));
    vecs.push_back(mk(1, 1, 0, 10'h002, 1, 1, 1,  1, 10'h002, 0,  0, 10'h000, 0));
    vecs.push_back(mk(1, 1, 1, 10'h003, 1, 1, 1,  1, 10'h003, 1,  0, 10'h000, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 1, 1, 1,  0, 10'h000, 0,  0, 10'h000, 0));
    // backpressure on y0: hold 0AA, stall a second y0 beat, y1 beat still flows
    vecs.push_back(mk(1, 0, 1, 10'h0AA, 0, 1, 1,  1, 10'h0AA, 1,  0, 10'h000, 0));
    vecs.push_back(mk(1, 0, 1, 10'h0BB, 0, 1, 0,  1, 10'h0AA, 1,  0, 10'h000, 0));
    vecs.push_back(mk(1, 1, 1, 10'h0CC, 0, 1, 1,  1, 10'h0AA, 1,  1, 10'h0CC, 1));
    vecs.push_back(mk(0, 0, 0, 10'h000, 1, 1, 1,  0, 10'h000, 0,  0, 10'h000, 0));
    // full throughput: eight back-to-back single-beat words to y0
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 1, W'(i), 1, 0, 1,  1, W'(i), 1,  0, 10'h000, 0));
    vecs.push_back(mk(0, 0, 0, 10'h000, 1, 1, 1,  0, 10'h000, 0,  0, 10'h000, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].last, vecs[i].d, vecs[i].r0, vecs[i].r1);
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d_y0_valid", i), 32'(y0_valid), 32'(vecs[i].e0v));
      check($sformatf("vec%0d_y1_valid", i), 32'(y1_valid), 32'(vecs[i].e1v));
      if (vecs[i].e0v) begin
        check($sformatf("vec%0d_y0_data", i), 32'(y0_data), 32'(vecs[i].e0d));
        check($sformatf("vec%0d_y0_last", i), 32'(y0_last), 32'(vecs[i].e0l));
      end
      if (vecs[i].e1v) begin
        check($sformatf("vec%0d_y1_data", i), 32'(y1_data), 32'(vecs[i].e1d));
        check($sformatf("vec%0d_y1_last", i), 32'(y1_last), 32'(vecs[i].e1l));
      end
    end

    // Async reset mid-packet: first beat locked to y1 and held by backpressure.
    drive(1, 1, 0, 10'h3FF, 1, 0);
    @(posedge clk); #1;
    check("rstmid_y1_valid_before", 32'(y1_valid), 32'd1);
    drive(0, 1, 0, 10'h000, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_y1_valid_async", 32'(y1_valid), 32'd0);
    check("rstmid_y1_data_async",  32'(y1_data),  32'd0);
    #2;
    rst_n = 1'b1;
    drive(1, 0, 1, 10'h012, 0, 0);
    #1;
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("rstmid_y0_valid", 32'(y0_valid), 32'd1);
    check("rstmid_y0_data",  32'(y0_data),  32'h012);
    check("rstmid_y1_valid", 32'(y1_valid), 32'd0);
    drive(0, 0, 0, 10'h000, 1, 1);
    @(posedge clk); #1;
    check("rstmid_drained", 32'(y0_valid), 32'd0);

    // Randomized traffic against the reference model.
    model_reset();
    m_cnt[0] = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rd = W'($urandom);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0), rd,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      #1;
      rdy     = {y1_ready, y0_ready};
      d       = m_mid ? m_dest : in_sel;
      exp_rdy = !m_full[d] || rdy[d];
      check("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = in_valid && exp_rdy;
      @(posedge clk);
      for (int n = 0; n < 2; n++) begin
        if (m_full[n] && rdy[n]) begin
          if (m_last[n]) m_cnt[n]++;
          m_full[n] = 1'b0;
        end
      end
      if (acc) begin
        m_full[d] = 1'b1;
        m_data[d] = in_data;
        m_last[d] = in_last;
        if (in_last) m_mid = 1'b0;
        else if (!m_mid) begin
          m_mid  = 1'b1;
          m_dest = in_sel;
        end
      end
      #1;
      check_outputs_vs_model("rand");
    end

`ifdef DEMUX_CNT_EN
    // Packet counters from a clean reset, including wrap at 65535.
    drive(0, 0, 0, 10'h000, 1, 1);
    #2; rst_n = 1'b0; #1;
    check("cnt_reset0", 32'(cnt0), 32'd0);
    check("cnt_reset1", 32'(cnt1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 0, 1, 10'h001, 1, 1); @(posedge clk); #1;
    drive(1, 1, 1, 10'h002, 1, 1); @(posedge clk); #1;
    drive(1, 0, 1, 10'h003, 1, 1); @(posedge clk); #1;
    drive(0, 0, 0, 10'h000, 1, 1); @(posedge clk); #1;
    check("cnt_two_y0", 32'(cnt0), 32'd2);
    check("cnt_one_y1", 32'(cnt1), 32'd1);
    drive(1, 0, 1, 10'h005, 1, 1);
    for (int i = 0; i < 65533; i++) @(posedge clk);
    #1;
    drive(0, 0, 0, 10'h000, 1, 1); @(posedge clk); #1;
    check("cnt_at_max", 32'(cnt0), 32'd65535);
    drive(1, 0, 1, 10'h006, 1, 1); @(posedge clk); #1;
    drive(0, 0, 0, 10'h000, 1, 1); @(posedge clk); #1;
    check("cnt_wrap", 32'(cnt0), 32'd0);
    check("cnt_y1_unchanged", 32'(cnt1), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
